// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//
// Multi-cycle execute stage that sits directly after the register file read
// ports. It accepts two operands, an opcode and a destination register index
// from issue. Single-cycle ALU operations finish in one cycle. MUL runs an
// iterative shift-add over DATA_W cycles. The stage then hands the result,
// destination index and write enable to the register file write port.
// Valid/ready handshakes decouple both sides.
//
// Optional feature: define EXEC_DIV_EN to add an iterative unsigned restoring
// divider for DIVU/REMU. Without that macro, those opcodes are illegal and no
// divider logic is built.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   flush       synchronous abort of any in-flight op (beats accept/out_ready)
//   in_valid    issue presents an op
//   in_ready    unit can accept an op (only in IDLE)
//   in_op       4-bit opcode
//   in_a/in_b   operands A and B (register file read data 1 / 2)
//   in_rd       destination register index
//   out_valid   result valid; held until out_ready
//   out_ready   writeback accepts the result
//   out_result  result data
//   out_rd      destination register index
//   out_wr      register-file write enable (never for register 0)
//   out_err     illegal-opcode flag, qualified by out_valid
//   busy        high while an op is computing or waiting to be drained
// -----------------------------------------------------------------------------
module exec_unit #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 6,
   parameter int SHAMT_W    = $clog2(DATA_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [DATA_W-1:0]     in_a,
   input  logic [DATA_W-1:0]     in_b,
   input  logic [REG_ADDR_W-1:0] in_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_result,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_wr,
   output logic                  out_err,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10,
      OP_DIVU = 4'd11,
      OP_REMU = 4'd12
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Opcodes above this value are illegal; the divide opcodes only count as
   // legal when the divider is built.
`ifdef EXEC_DIV_EN
   localparam logic [3:0] LAST_LEGAL_OP = OP_REMU;
`else
   localparam logic [3:0] LAST_LEGAL_OP = OP_MUL;
`endif

   state_t state_q, state_d;
   logic   accept;

   // Iteration registers. For MUL: a_q = multiplicand (shifts left),
   // b_q = multiplier (shifts right), acc_q = running product.
   // For divide: a_q = dividend turning into quotient, b_q = divisor,
   // acc_q = partial remainder.
   logic [DATA_W-1:0]     a_q, b_q, acc_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_W-1:0]     res_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  err_q;
`ifdef EXEC_DIV_EN
   logic [3:0]            op_q;
`endif

   logic [DATA_W-1:0]  alu_res;
   logic [SHAMT_W-1:0] shamt;
   logic               op_legal;
   logic               op_iter;
   logic               last_iter;

   logic [DATA_W-1:0]  mul_acc_nxt;
   logic [DATA_W-1:0]  step_acc, step_a, step_b, step_res;

   assign shamt     = in_b[SHAMT_W-1:0];
   assign op_legal  = (in_op <= LAST_LEGAL_OP);
   assign op_iter   = op_legal && (in_op >= OP_MUL);
   assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

   // ---------------------------------------------------------------------------
   // Single-cycle ALU, evaluated on the issue operands so the result can be
   // registered on the accept edge.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      alu_res = '0;
      case (in_op)
         OP_ADD:  alu_res = in_a + in_b;
         OP_SUB:  alu_res = in_a - in_b;
         OP_AND:  alu_res = in_a & in_b;
         OP_OR:   alu_res = in_a | in_b;
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_SLT:  alu_res[0] = ($signed(in_a) < $signed(in_b));
         OP_SLTU: alu_res[0] = (in_a < in_b);
         OP_SLL:  alu_res = in_a << shamt;
         OP_SRL:  alu_res = in_a >> shamt;
         OP_SRA:  alu_res = $signed(in_a) >>> shamt;
         default: alu_res = '0;   // MUL/DIV are produced later; illegal ops give 0
      endcase
   end

   // ---------------------------------------------------------------------------
   // One iteration of the multi-cycle datapath.
   // ---------------------------------------------------------------------------
   assign mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);

`ifdef EXEC_DIV_EN
   // Restoring division step: shift the next dividend bit into the partial
   // remainder, and subtract the divisor when it fits. The quotient bit is
   // shifted into the vacated LSB of a_q. A zero divisor always "fits", so the
   // quotient becomes all ones and the remainder becomes the dividend.
   logic [DATA_W:0]   rem_shift;
   logic              div_ge;
   logic [DATA_W-1:0] rem_nxt, quo_nxt;

   assign rem_shift = {acc_q, a_q[DATA_W-1]};
   assign div_ge    = (rem_shift >= {1'b0, b_q});
   assign rem_nxt   = div_ge ? (rem_shift[DATA_W-1:0] - b_q) : rem_shift[DATA_W-1:0];
   assign quo_nxt   = {a_q[DATA_W-2:0], div_ge};
`endif

   always_comb begin
      step_acc = mul_acc_nxt;
      step_a   = a_q << 1;
      step_b   = b_q >> 1;
      step_res = mul_acc_nxt;
`ifdef EXEC_DIV_EN
      if (op_q != OP_MUL) begin
         step_acc = rem_nxt;
         step_a   = quo_nxt;
         step_b   = b_q;
         step_res = (op_q == OP_DIVU) ? quo_nxt : rem_nxt;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         IDLE: in_ready  = 1'b1;
         CALC: busy      = 1'b1;
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase

      if (flush) begin
         // Abort wins over both a new accept and a pending writeback.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  accept  = 1'b1;
                  state_d = op_iter ? CALC : DONE;
               end
            end
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the datapath registers are plain flops, not memories, so they are cleared on reset. That keeps the result outputs at 0 after reset.
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         res_q <= '0;
         rd_q  <= '0;
         err_q <= 1'b0;
`ifdef EXEC_DIV_EN
         op_q  <= '0;
`endif
      end else if (accept) begin
         a_q   <= in_a;
         b_q   <= in_b;
         acc_q <= '0;
         cnt_q <= '0;
         res_q <= alu_res;
         rd_q  <= in_rd;
         err_q <= ~op_legal;
`ifdef EXEC_DIV_EN
         op_q  <= in_op;
`endif
      end else if (state_q == CALC && !flush) begin
         acc_q <= step_acc;
         a_q   <= step_a;
         b_q   <= step_b;
         cnt_q <= cnt_q + CNT_W'(1);
         if (last_iter) res_q <= step_res;
      end
   end

   assign out_result = res_q;
   assign out_rd     = rd_q;
   assign out_err    = err_q;
   assign out_wr     = out_valid & (rd_q != '0);

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit
//
// Directed self-checking bench for exec_unit (DATA_W=32, REG_ADDR_W=6).
// Each issued op pushes its expected result onto a scoreboard queue. The entry
// is popped and compared when out_valid appears. Expected results are
// hand-computed constants. Define EXEC_DIV_EN for both bench and RTL to check
// the divider build.
// -----------------------------------------------------------------------------
module tb_exec_unit;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 6;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_DIVU = 4'd11;
   localparam logic [3:0] OP_REMU = 4'd12;

   logic                  clk;
   logic                  rst;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_op;
   logic [DATA_W-1:0]     in_a;
   logic [DATA_W-1:0]     in_b;
   logic [REG_ADDR_W-1:0] in_rd;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_result;
   logic [REG_ADDR_W-1:0] out_rd;
   logic                  out_wr;
   logic                  out_err;
   logic                  busy;

   exec_unit #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_rd      (in_rd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd),
      .out_wr     (out_wr),
      .out_err    (out_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0]     res;
      logic [REG_ADDR_W-1:0] rd;
      logic                  err;
      int                    lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   xfers  = 0;
   int   x0;
   bit   seen;

   // Count writeback transfers; a flushed handshake is not a transfer.
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready && !flush) xfers++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait (bounded) for its result, compare against the
   // scoreboard, optionally hold out_ready low for `hold` cycles, then drain.
   // Called and returns at #1 after a rising edge.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [REG_ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] exp_res, input logic exp_err,
                         input int exp_lat, input int hold, input bit early_ready);
      exp_t e;
      int   lat;
      bit   wait_ok;
      int   xs;
      check({tag, ":in_ready_before"}, in_ready, 1);
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_rd     = rd;
      in_valid  = 1'b1;
      out_ready = early_ready;
      sb.push_back('{exp_res, rd, exp_err, exp_lat});
      xs = xfers;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = '1;          // must be ignored outside IDLE
      lat      = 1;
      wait_ok  = 1'b1;
      while (!out_valid && lat < 200) begin
         if (!busy || in_ready) wait_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ":busy_while_calc"}, wait_ok, 1);
      check({tag, ":latency"}, lat, exp_lat);
      check({tag, ":sb_level"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, ":out_valid"}, out_valid, 1);
         check({tag, ":result"}, out_result, e.res);
         check({tag, ":rd"}, out_rd, e.rd);
         check({tag, ":err"}, out_err, e.err);
         check({tag, ":wr"}, out_wr, (e.rd != '0));
         check({tag, ":in_ready_done"}, in_ready, 0);
         if (hold > 0) begin
            repeat (hold) begin
               @(posedge clk); #1;
            end
            check({tag, ":held_valid"}, out_valid, 1);
            check({tag, ":held_result"}, out_result, e.res);
            check({tag, ":held_xfers"}, xfers - xs, 0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":xfer_count"}, xfers - xs, 1);
      check({tag, ":drained_valid"}, out_valid, 0);
      check({tag, ":drained_in_ready"}, in_ready, 1);
      check({tag, ":drained_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_rd     = '0;
      out_ready = 1'b0;

      // Reset values, and no transfer while rst is high.
      repeat (2) @(posedge clk);
      #1;
      check("rst:in_ready", in_ready, 1);
      check("rst:out_valid", out_valid, 0);
      check("rst:busy", busy, 0);
      check("rst:result", out_result, 0);
      check("rst:rd", out_rd, 0);
      check("rst:err", out_err, 0);
      check("rst:wr", out_wr, 0);
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_a     = 32'd3;
      in_b     = 32'd4;
      in_rd    = 6'd9;
      @(posedge clk); #1;
      check("rst:no_accept_valid", out_valid, 0);
      check("rst:no_accept_busy", busy, 0);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk); #1;
      check("post_rst:out_valid", out_valid, 0);

      // Single-cycle ALU ops.
      run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 6'd5, 32'h0000_0001, 1'b0, 1, 0, 1'b1);
      run_op("sub", OP_SUB, 32'd5, 32'd7, 6'd1, 32'hFFFF_FFFE, 1'b0, 1, 0, 1'b0);
      run_op("and", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd2, 32'h00F0_00F0, 1'b0, 1, 0, 1'b0);
      run_op("or", OP_OR, 32'h1234_0000, 32'h0000_5678, 6'd3, 32'h1234_5678, 1'b0, 1, 0, 1'b0);
      run_op("xor", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 6'd4, 32'hF0F0_0F0F, 1'b0, 1, 0, 1'b0);
      run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 6'd6, 32'd1, 1'b0, 1, 0, 1'b0);
      run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 6'd7, 32'd0, 1'b0, 1, 0, 1'b0);
      run_op("sll", OP_SLL, 32'd1, 32'h0000_003F, 6'd8, 32'h8000_0000, 1'b0, 1, 0, 1'b0);
      run_op("srl", OP_SRL, 32'h8000_0000, 32'd4, 6'd10, 32'h0800_0000, 1'b0, 1, 0, 1'b0);
      run_op("sra_hold", OP_SRA, 32'h8000_0000, 32'h0000_0021, 6'd11, 32'hC000_0000, 1'b0, 1, 5, 1'b0);

      // Iterative multiply.
      run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 6'd3, 32'd42, 1'b0, 33, 0, 1'b0);
      run_op("mul_neg", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 32'd1, 1'b0, 33, 0, 1'b1);

      // Illegal opcodes.
      run_op("illegal14_r0", 4'd14, 32'd9, 32'd9, 6'd0, 32'd0, 1'b1, 1, 0, 1'b0);
      run_op("illegal15", 4'd15, 32'd1, 32'd2, 6'd13, 32'd0, 1'b1, 1, 0, 1'b0);

      // Divide ops.
`ifdef EXEC_DIV_EN
      run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 6'd14, 32'hFFFF_FFFF, 1'b0, 33, 0, 1'b0);
      run_op("remu", OP_REMU, 32'd100, 32'd7, 6'd15, 32'd2, 1'b0, 33, 0, 1'b0);
`else
      run_op("divu_illegal", OP_DIVU, 32'd100, 32'd0, 6'd14, 32'd0, 1'b1, 1, 0, 1'b0);
      run_op("remu_illegal", OP_REMU, 32'd100, 32'd7, 6'd15, 32'd0, 1'b1, 1, 0, 1'b0);
`endif

      // Flush a MUL on cycle 10 after accept: no result ever appears.
      x0        = xfers;
      in_op     = OP_MUL;
      in_a      = 32'd3;
      in_b      = 32'd5;
      in_rd     = 6'd2;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen     = 1'b0;
      repeat (9) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_calc:in_ready", in_ready, 1);
      check("flush_calc:busy", busy, 0);
      repeat (40) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("flush_calc:no_valid", seen, 0);
      check("flush_calc:no_xfer", xfers - x0, 0);
      run_op("add_after_flush", OP_ADD, 32'd1, 32'd1, 6'd4, 32'd2, 1'b0, 1, 0, 1'b0);

      // Flush in IDLE with in_valid high: nothing is accepted.
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_rd    = 6'd20;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_idle:out_valid", out_valid, 0);
      check("flush_idle:busy", busy, 0);
      @(posedge clk); #1;
      check("flush_idle:still_idle", out_valid, 0);

      // Flush in DONE together with out_ready: no transfer, valid drops.
      x0        = xfers;
      in_op     = OP_OR;
      in_a      = 32'd1;
      in_b      = 32'd2;
      in_rd     = 6'd9;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("flush_done:valid", out_valid, 1);
      check("flush_done:result", out_result, 32'd3);
      flush     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      flush     = 1'b0;
      out_ready = 1'b0;
      check("flush_done:dropped", out_valid, 0);
      check("flush_done:in_ready", in_ready, 1);
      check("flush_done:no_xfer", xfers - x0, 0);

      // Asynchronous reset while a result is held in DONE.
      in_op    = OP_XOR;
      in_a     = 32'hA5A5_0000;
      in_b     = 32'h0000_5A5A;
      in_rd    = 6'd33;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rst_done:valid", out_valid, 1);
      check("rst_done:result", out_result, 32'hA5A5_5A5A);
      #2;
      rst = 1'b1;
      #1;
      check("rst_done:async_valid", out_valid, 0);
      check("rst_done:async_result", out_result, 0);
      check("rst_done:async_rd", out_rd, 0);
      check("rst_done:async_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_done:idle_after", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Multi-cycle execute stage directly downstream of the register file read ports.
- Accepts two operands, an opcode and a destination index.
- Computes single-cycle ALU ops or an iterative multiply (optional divide).
- Returns result, destination index and write-enable for the register file write port.
- Decoupled from issue and writeback by valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, operand/result width in bits; must be a power of two, 8 to 64.
REG_ADDR_W, 6, register index width.
SHAMT_W, $clog2(DATA_W), shift-amount bits taken from op_b.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort of any in-flight op
in_valid  input  1  issue presents a valid op
in_ready  output  1  unit can accept; high only in IDLE
in_op  input  4  opcode (encoding below)
in_a  input  DATA_W  operand A (read_data_1)
in_b  input  DATA_W  operand B (read_data_2)
in_rd  input  REG_ADDR_W  destination register index
out_valid  output  1  result valid, held until accepted
out_ready  input  1  writeback accepts result
out_result  output  DATA_W  result
out_rd  output  REG_ADDR_W  destination index
out_wr  output  1  = out_valid & (out_rd != 0); register 0 never written
out_err  output  1  illegal opcode flag, qualified by out_valid
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: state IDLE; out_valid=0, out_result=0, out_rd=0, out_err=0, busy=0; counter and accumulators cleared.
- in_ready reads 1 while rst is high, but no transfer occurs during reset.
- Reset mid-operation discards the op.
- Opcodes (all arithmetic modulo 2^DATA_W):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU: result 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift by in_b[SHAMT_W-1:0].
  - 10 MUL: low DATA_W bits of the product.
  - 11 DIVU, 12 REMU: optional feature only.
  - 13-15 illegal.
- Transfer occurs when in_valid & in_ready at a clock edge. op, a, b and rd are latched on transfer.
- FSM IDLE -> DONE, for single-cycle ops and illegal ops:
  - Result registered at the accept edge.
  - out_valid rises the cycle after accept (latency 1).
- FSM IDLE -> CALC -> DONE, for MUL:
  - Shift-add: each cycle, if b[0] then acc += a; then a <<= 1, b >>= 1; counter increments.
  - After DATA_W iterations, go to DONE.
  - out_valid asserts DATA_W+1 cycles after accept.
- DONE:
  - out_result, out_rd, out_err and out_valid stay stable until out_valid & out_ready.
  - On that edge, go to IDLE.
  - in_ready=0 in DONE, so peak throughput is one op per 2 cycles.
- Illegal opcode: out_result=0, out_err=1, out_wr still follows in_rd; writeback decides whether to discard.
- flush:
  - In any state, at the next edge go to IDLE and drop out_valid; no result is emitted.
  - flush has priority over accept and over out_ready.
  - flush in IDLE with in_valid high: no accept.
- out_ready is ignored when out_valid=0.
- in_* inputs are ignored outside IDLE.

Optional Feature:
Macro EXEC_DIV_EN.
- Defined:
  - Ops 11/12 perform unsigned restoring division: DATA_W iterations in CALC, latency DATA_W+1.
  - Divide by zero: DIVU result = all ones, REMU result = in_a; still DATA_W+1 latency; out_err=0.
- Undefined:
  - Ops 11/12 are treated as illegal: latency 1, out_result=0, out_err=1.
  - No divider logic is synthesized.

Test Plan:
- ADD a=0xFFFFFFFF, b=2, rd=5, out_ready=1 -> out_valid 1 cycle after accept; result 0x00000001, out_rd=5, out_wr=1.
- MUL a=7, b=6, rd=3 -> out_valid exactly 33 cycles after accept; result 42; in_ready=0 and busy=1 throughout.
- SRA a=0x80000000, b=0x21, with out_ready held low 5 cycles -> result 0xC0000000 held stable; exactly one transfer when out_ready rises; then IDLE, in_ready=1.
- MUL accepted, flush pulsed on cycle 10 -> no out_valid ever; in_ready=1 next cycle; a following ADD 1+1 returns 2.
- Opcode 14, rd=0 -> out_valid after 1 cycle; out_err=1, result 0, out_wr=0.
- DIVU 100/0 and REMU 100/7:
  - With EXEC_DIV_EN: 0xFFFFFFFF and 2, both at latency 33.
  - Without EXEC_DIV_EN: out_err=1 at latency 1.
